// File: rtl/rd_req_split.sv
// Splits DMA read-request heads into PCIe-legal AXIS read requests with one tag each.
// Latency: first sub-request valid one edge after the ISSUE entry, then 1 sub-request/cycle.
// Backpressure: tuser/tvalid held while !tready; ISSUE stalls on a busy output or an empty tag pool.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   dma_rd_req_*                single-beat request head in (type, 64b address, 13b byte length)
//   axis_rd_req_*               header-only sub-request out (tag, address, DW length, byte enables)
//   tag_rls_valid / tag_rls     tag returned by the completion side
//   ctx_*                       per-tag context, strobed on each sub-request handshake
//   max_rd_req_sz               MRRS code, 0..5 = 128..4096 B, 6/7 clamp to 4096 B
module rd_req_split #(
  parameter int TAG_NUM = 32,
  parameter int TAG_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dma_rd_req_valid,
  input  logic [127:0]      dma_rd_req_head,
  output logic              dma_rd_req_ready,
  output logic              axis_rd_req_tvalid,
  output logic              axis_rd_req_tlast,
  output logic [127:0]      axis_rd_req_tuser,
  input  logic              axis_rd_req_tready,
  input  logic              tag_rls_valid,
  input  logic [TAG_W-1:0]  tag_rls,
  output logic              ctx_valid,
  output logic [TAG_W-1:0]  ctx_tag,
  output logic [12:0]       ctx_byte_len,
  output logic [6:0]        ctx_addr_lo,
  output logic              ctx_last,
  input  logic [2:0]        max_rd_req_sz
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t               state_q, state_d;
  logic [3:0]           type_q, type_d;
  logic [63:0]          addr_q, addr_d;
  logic [12:0]          rem_q, rem_d;
  logic [TAG_NUM-1:0]   busy_q, busy_d;
  logic                 rdy_q, rdy_d;
  logic                 vld_q, vld_d;
  logic [127:0]         user_q, user_d;
  logic [TAG_W-1:0]     ctag_q, ctag_d;
  logic [12:0]          clen_q, clen_d;
  logic [6:0]           calo_q, calo_d;
  logic                 clast_q, clast_d;

  logic                 hs;
  logic [2:0]           sz_eff;
  logic [12:0]          mrrs;
  logic [12:0]          room;
  logic [12:0]          chunk;
  logic [12:0]          dw_sum;
  logic [10:0]          dw_len;
  logic [1:0]           end_lo;
  logic [3:0]           fbe_raw, lbe_raw, fbe, lbe;
  logic                 free_any;
  logic [TAG_W-1:0]     free_idx;
  logic [7:0]           tag8;
  logic                 unused_bits;

  assign hs = vld_q & axis_rd_req_tready;

  // Next chunk: bounded by the bytes left and by the distance to the next
  // MRRS-aligned boundary (MRRS <= 4096, so 4KB is never crossed either).
  always_comb begin
    sz_eff  = (max_rd_req_sz > 3'd5) ? 3'd5 : max_rd_req_sz;
    mrrs    = 13'd128 << sz_eff;
    room    = mrrs - ({1'b0, addr_q[11:0]} & (mrrs - 13'd1));
    chunk   = (rem_q < room) ? rem_q : room;
    dw_sum  = 13'(addr_q[1:0]) + chunk + 13'd3;
    dw_len  = dw_sum[12:2];
    end_lo  = addr_q[1:0] + chunk[1:0] - 2'd1;
    fbe_raw = 4'hF << addr_q[1:0];
    lbe_raw = 4'hF >> (2'd3 - end_lo);
    // A single-DW request carries all its enables in the first BE field.
    if (dw_len == 11'd1) begin
      fbe = fbe_raw & lbe_raw;
      lbe = 4'h0;
    end else begin
      fbe = fbe_raw;
      lbe = lbe_raw;
    end
  end

  // Lowest-index free tag; scanning downward lets the lowest index win.
  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    for (int i = TAG_NUM - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_any = 1'b1;
        free_idx = TAG_W'(i);
      end
    end
    tag8 = 8'(free_idx);
  end

  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    busy_d  = busy_q;
    vld_d   = vld_q;
    user_d  = user_q;
    ctag_d  = ctag_q;
    clen_d  = clen_q;
    calo_d  = calo_q;
    clast_d = clast_q;

    // Release first so an allocation in the same cycle still marks its own tag busy.
    if (tag_rls_valid) begin
      busy_d[tag_rls] = 1'b0;
    end
    if (hs) begin
      vld_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (rdy_q && dma_rd_req_valid) begin
          type_d = dma_rd_req_head[99:96];
          addr_d = dma_rd_req_head[95:32];
          rem_d  = dma_rd_req_head[12:0];
          // Zero-length heads are consumed without issuing anything.
          if (dma_rd_req_head[12:0] != 13'd0) begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if ((!vld_q || hs) && free_any) begin
          vld_d           = 1'b1;
          user_d          = '0;
          user_d[107:104] = type_q;
          user_d[103:96]  = tag8;
          user_d[95:32]   = addr_q;
          user_d[18:8]    = dw_len;
          user_d[7:4]     = fbe;
          user_d[3:0]     = lbe;
          ctag_d          = free_idx;
          clen_d          = chunk;
          calo_d          = addr_q[6:0];
          clast_d         = (chunk == rem_q);
          busy_d[free_idx] = 1'b1;
          addr_d          = addr_q + 64'(chunk);
          rem_d           = rem_q - chunk;
          if (chunk == rem_q) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (hs) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Registered ready keeps it low while reset is held.
    rdy_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      type_q  <= '0;
      addr_q  <= '0;
      rem_q   <= '0;
      busy_q  <= '0;
      rdy_q   <= 1'b0;
      vld_q   <= 1'b0;
      user_q  <= '0;
      ctag_q  <= '0;
      clen_q  <= '0;
      calo_q  <= '0;
      clast_q <= 1'b0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      rdy_q   <= rdy_d;
      vld_q   <= vld_d;
      user_q  <= user_d;
      ctag_q  <= ctag_d;
      clen_q  <= clen_d;
      calo_q  <= calo_d;
      clast_q <= clast_d;
    end
  end

  assign dma_rd_req_ready   = rdy_q;
  assign axis_rd_req_tvalid = vld_q;
  assign axis_rd_req_tlast  = 1'b1;
  assign axis_rd_req_tuser  = user_q;
  // Context is written exactly when the sub-request is handed downstream.
  assign ctx_valid          = hs;
  assign ctx_tag            = ctag_q;
  assign ctx_byte_len       = clen_q;
  assign ctx_addr_lo        = calo_q;
  assign ctx_last           = clast_q;

  assign unused_bits = ^{dma_rd_req_head[127:100], dma_rd_req_head[31:13], dw_sum[1:0]};

endmodule
